// File: rtl/risc_exec_unit.sv
// risc_exec_unit: ALU plus word-addressed data memory, sequenced by a start/done FSM.
// Define RISC_MAC_EN to enable op C (MUL) and op D (MAC with internal accumulator).
module risc_exec_unit #(
   parameter int DW    = 32,
   parameter int AW    = 16,
   parameter int DEPTH = 256
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [3:0]    op,
   input  logic [DW-1:0] A,
   input  logic [DW-1:0] B,
   input  logic [AW-1:0] ADD,
   input  logic          Asel,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] ALU_out,
   output logic [DW-1:0] Data_out,
   output logic          zero,
   output logic          carry,
   output logic          ovf,
   output logic          err
);

   // state   | meaning
   // S_IDLE  | waiting for start; operands latched on accept
   // S_FETCH | synchronous read of mem[idx] into rdata
   // S_EXEC  | compute result and flags; STORE writes memory
   // S_MAC   | accumulate step for MAC (RISC_MAC_EN only)
   // S_WB    | commit result to outputs; done pulses on the following cycle

   localparam int IW = $clog2(DEPTH);
   localparam int SW = $clog2(DW);

   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_AND   = 4'h2;
   localparam logic [3:0] OP_OR    = 4'h3;
   localparam logic [3:0] OP_XOR   = 4'h4;
   localparam logic [3:0] OP_NOT   = 4'h5;
   localparam logic [3:0] OP_PASS  = 4'h6;
   localparam logic [3:0] OP_SLL   = 4'h7;
   localparam logic [3:0] OP_SRL   = 4'h8;
   localparam logic [3:0] OP_SRA   = 4'h9;
   localparam logic [3:0] OP_LOAD  = 4'hA;
   localparam logic [3:0] OP_STORE = 4'hB;
   localparam logic [3:0] OP_MUL   = 4'hC;
   localparam logic [3:0] OP_MAC   = 4'hD;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_MAC,
      S_WB
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    op_q, op_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          asel_q, asel_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [DW-1:0] res_q, res_d;
   logic          res_c_q, res_c_d;
   logic          res_v_q, res_v_d;
   logic          res_e_q, res_e_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [DW-1:0] alu_out_q, alu_out_d;
   logic [DW-1:0] data_out_q, data_out_d;
   logic          zero_q, zero_d;
   logic          carry_q, carry_d;
   logic          ovf_q, ovf_d;
   logic          err_q, err_d;
`ifdef RISC_MAC_EN
   logic [DW-1:0] acc_q, acc_d;
   logic [DW-1:0] prod_q, prod_d;
   logic [DW-1:0] mul_lo;
`endif

   logic [DW-1:0] mem_q [DEPTH];
   logic          mem_we;

   logic [DW-1:0] opa;
   logic [DW:0]   sum;
   logic [DW:0]   dif;
   logic [SW-1:0] sh;
   logic [DW-1:0] alu_res;
   logic          alu_c;
   logic          alu_v;
   logic          alu_e;

   generate
      if (AW > IW) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^ADD[AW-1:IW];
      end
   endgenerate

   always_comb begin
      opa     = asel_q ? rdata_q : a_q;
      sum     = {1'b0, opa} + {1'b0, b_q};
      // Subtract as A + ~B + 1 so the carry out reads directly as "no borrow".
      dif     = {1'b0, opa} + {1'b0, ~b_q} + {{DW{1'b0}}, 1'b1};
      sh      = b_q[SW-1:0];
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_e   = 1'b0;
`ifdef RISC_MAC_EN
      mul_lo  = opa * b_q;
`endif
      case (op_q)
         OP_ADD: begin
            alu_res = sum[DW-1:0];
            alu_c   = sum[DW];
            alu_v   = (opa[DW-1] == b_q[DW-1]) && (sum[DW-1] != opa[DW-1]);
         end
         OP_SUB: begin
            alu_res = dif[DW-1:0];
            alu_c   = dif[DW];
            alu_v   = (opa[DW-1] != b_q[DW-1]) && (dif[DW-1] != opa[DW-1]);
         end
         OP_AND:   alu_res = opa & b_q;
         OP_OR:    alu_res = opa | b_q;
         OP_XOR:   alu_res = opa ^ b_q;
         OP_NOT:   alu_res = ~opa;
         OP_PASS:  alu_res = b_q;
         OP_SLL:   alu_res = opa << sh;
         OP_SRL:   alu_res = opa >> sh;
         OP_SRA:   alu_res = $signed(opa) >>> sh;
         OP_LOAD:  alu_res = rdata_q;
         OP_STORE: alu_res = b_q;
`ifdef RISC_MAC_EN
         OP_MUL:   alu_res = mul_lo;
         OP_MAC:   alu_res = acc_q + mul_lo;
`endif
         default:  alu_e   = 1'b1;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      idx_d      = idx_q;
      asel_d     = asel_q;
      rdata_d    = rdata_q;
      res_d      = res_q;
      res_c_d    = res_c_q;
      res_v_d    = res_v_q;
      res_e_d    = res_e_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      alu_out_d  = alu_out_q;
      data_out_d = data_out_q;
      zero_d     = zero_q;
      carry_d    = carry_q;
      ovf_d      = ovf_q;
      err_d      = err_q;
      mem_we     = 1'b0;
`ifdef RISC_MAC_EN
      acc_d      = acc_q;
      prod_d     = prod_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               a_d     = A;
               b_d     = B;
               idx_d   = ADD[IW-1:0];
               asel_d  = Asel;
               busy_d  = 1'b1;
               state_d = (Asel || op == OP_LOAD) ? S_FETCH : S_EXEC;
            end
         end
         S_FETCH: begin
            rdata_d = mem_q[idx_q];
            state_d = S_EXEC;
         end
         S_EXEC: begin
            res_d   = alu_res;
            res_c_d = alu_c;
            res_v_d = alu_v;
            res_e_d = alu_e;
            mem_we  = (op_q == OP_STORE);
            state_d = S_WB;
`ifdef RISC_MAC_EN
            if (op_q == OP_MAC) begin
               prod_d  = mul_lo;
               state_d = S_MAC;
            end
`endif
         end
`ifdef RISC_MAC_EN
         S_MAC: begin
            acc_d   = acc_q + prod_q;
            res_d   = acc_q + prod_q;
            state_d = S_WB;
         end
`endif
         S_WB: begin
            alu_out_d = res_q;
            zero_d    = (res_q == '0);
            carry_d   = res_c_q;
            ovf_d     = res_v_q;
            err_d     = res_e_q;
            if (asel_q || op_q == OP_LOAD) begin
               data_out_d = rdata_q;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         idx_q      <= '0;
         asel_q     <= 1'b0;
         rdata_q    <= '0;
         res_q      <= '0;
         res_c_q    <= 1'b0;
         res_v_q    <= 1'b0;
         res_e_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         alu_out_q  <= '0;
         data_out_q <= '0;
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
`ifdef RISC_MAC_EN
         acc_q      <= '0;
         prod_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         idx_q      <= idx_d;
         asel_q     <= asel_d;
         rdata_q    <= rdata_d;
         res_q      <= res_d;
         res_c_q    <= res_c_d;
         res_v_q    <= res_v_d;
         res_e_q    <= res_e_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         alu_out_q  <= alu_out_d;
         data_out_q <= data_out_d;
         zero_q     <= zero_d;
         carry_q    <= carry_d;
         ovf_q      <= ovf_d;
         err_q      <= err_d;
`ifdef RISC_MAC_EN
         acc_q      <= acc_d;
         prod_q     <= prod_d;
`endif
      end
   end

   // Memory is not reset; a reset during EXEC suppresses the pending store.
   always_ff @(posedge clk) begin
      if (rst && mem_we) begin
         mem_q[idx_q] <= b_q;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign ALU_out  = alu_out_q;
   assign Data_out = data_out_q;
   assign zero     = zero_q;
   assign carry    = carry_q;
   assign ovf      = ovf_q;
   assign err      = err_q;

endmodule

// File: tb/tb_risc_exec_unit.sv
// Self-checking bench for risc_exec_unit: directed ops against an arithmetic reference model.
module tb_risc_exec_unit;
   localparam int DW    = 32;
   localparam int AW    = 16;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [3:0]    op = 4'h0;
   logic [DW-1:0] A = '0;
   logic [DW-1:0] B = '0;
   logic [AW-1:0] ADD = '0;
   logic          Asel = 1'b0;
   logic          busy, done, zero, carry, ovf, err;
   logic [DW-1:0] ALU_out, Data_out;

   risc_exec_unit #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B), .ADD(ADD), .Asel(Asel),
      .busy(busy), .done(done), .ALU_out(ALU_out), .Data_out(Data_out),
      .zero(zero), .carry(carry), .ovf(ovf), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass = 0;
   int n_tot  = 0;
   bit chk_en = 1'b0;

   logic [DW-1:0] mdl_mem [DEPTH];
   logic [DW-1:0] mdl_acc;
   logic [DW-1:0] exp_alu, exp_dout, pend_alu, pend_dout;
   logic          exp_zero, exp_carry, exp_ovf, exp_err;
   logic          pend_zero, pend_carry, pend_ovf, pend_err;
   int            exp_start = -1;
   int            exp_done  = -1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_tot++;
      if (act === expv) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
   endtask

   task automatic reset_model();
      exp_alu = '0; exp_dout = '0; exp_zero = 0; exp_carry = 0; exp_ovf = 0; exp_err = 0;
      exp_start = -1; exp_done = -1; mdl_acc = '0;
   endtask

   // Reference: results from plain integer arithmetic on the operands.
   task automatic model_op(input logic [3:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [AW-1:0] ad, input bit as, output int lat);
      int            idx;
      bit            fetch;
      logic [DW-1:0] x;
      logic [63:0]   u;
      longint        s, smax, smin;
      idx   = int'(ad) % DEPTH;
      fetch = as || (o == 4'hA);
      x     = as ? mdl_mem[idx] : a;
      smax  = (longint'(1) <<< (DW-1)) - 1;
      smin  = -(longint'(1) <<< (DW-1));
      lat   = fetch ? 3 : 2;
      pend_dout  = fetch ? mdl_mem[idx] : exp_dout;
      pend_carry = 0; pend_ovf = 0; pend_err = 0; pend_alu = '0;
      case (o)
         4'h0: begin
            u = 64'(x) + 64'(b);
            pend_alu   = u[DW-1:0];
            pend_carry = (u >= (64'd1 << DW));
            s = longint'($signed(x)) + longint'($signed(b));
            pend_ovf   = (s > smax) || (s < smin);
         end
         4'h1: begin
            pend_alu   = x - b;
            pend_carry = (x >= b);
            s = longint'($signed(x)) - longint'($signed(b));
            pend_ovf   = (s > smax) || (s < smin);
         end
         4'h2: pend_alu = x & b;
         4'h3: pend_alu = x | b;
         4'h4: pend_alu = x ^ b;
         4'h5: pend_alu = ~x;
         4'h6: pend_alu = b;
         4'h7: pend_alu = x << (b % DW);
         4'h8: pend_alu = x >> (b % DW);
         4'h9: pend_alu = $signed(x) >>> (b % DW);
         4'hA: pend_alu = mdl_mem[idx];
         4'hB: begin pend_alu = b; mdl_mem[idx] = b; end
`ifdef RISC_MAC_EN
         4'hC: pend_alu = x * b;
         4'hD: begin mdl_acc = mdl_acc + x * b; pend_alu = mdl_acc; lat = lat + 1; end
`endif
         default: pend_err = 1;
      endcase
      pend_zero = (pend_alu == '0);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (cyc == exp_done) begin
            exp_alu = pend_alu; exp_dout = pend_dout; exp_zero = pend_zero;
            exp_carry = pend_carry; exp_ovf = pend_ovf; exp_err = pend_err;
         end
         chk("done",     64'(done),     64'(cyc == exp_done));
         chk("busy",     64'(busy),     64'(cyc >= exp_start && cyc < exp_done));
         chk("ALU_out",  64'(ALU_out),  64'(exp_alu));
         chk("Data_out", 64'(Data_out), 64'(exp_dout));
         chk("zero",     64'(zero),     64'(exp_zero));
         chk("carry",    64'(carry),    64'(exp_carry));
         chk("ovf",      64'(ovf),      64'(exp_ovf));
         chk("err",      64'(err),      64'(exp_err));
      end
   end

   task automatic run_op(input logic [3:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [AW-1:0] ad, input bit as, input bit poke);
      int lat;
      int guard;
      @(posedge clk); #2;
      op = o; A = a; B = b; ADD = ad; Asel = as; start = 1;
      @(posedge clk); #2;
      start = 0;
      model_op(o, a, b, ad, as, lat);
      exp_start = cyc;
      exp_done  = cyc + lat;
      op = 4'h6; A = '1; B = '1; ADD = '1; Asel = ~as;
      if (poke) begin
         @(posedge clk); #2; start = 1;
         @(posedge clk); #2; start = 0;
      end
      guard = 0;
      while (cyc < exp_done && guard < 20) begin
         @(posedge clk); #2;
         guard++;
      end
      if (cyc < exp_done) chk("done_wait_timeout", 64'(cyc), 64'(exp_done));
   endtask

   typedef struct {
      logic [3:0]    o;
      logic [DW-1:0] a, b, r;
      logic          c, v;
   } vec_t;

   vec_t vt [9] = '{
      '{4'h4, 32'h0F0F0F0F, 32'hFFFF0000, 32'hF0F00F0F, 1'b0, 1'b0},
      '{4'h3, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0},
      '{4'h5, 32'h0000FFFF, 32'h00000000, 32'hFFFF0000, 1'b0, 1'b0},
      '{4'h6, 32'h00000001, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0},
      '{4'h7, 32'h00000001, 32'h00000024, 32'h00000010, 1'b0, 1'b0},
      '{4'h8, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0},
      '{4'h9, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0},
      '{4'h1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0},
      '{4'h1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1}
   };

   initial begin
      rst = 0; start = 1; op = 4'h0; A = 32'd1; B = 32'd1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_alu", 64'(ALU_out), 0);
      chk("rst_dout", 64'(Data_out), 0);
      chk("rst_flags", {60'd0, zero, carry, ovf, err}, 0);
      @(posedge clk); #2;
      start = 0; rst = 1;
      reset_model();
      chk_en = 1;

      run_op(4'h0, 32'd5, 32'd7, 16'h0, 0, 0);
      chk("add5_7", 64'(ALU_out), 12);
      chk("add5_7_zc", {zero, carry}, 0);
      chk("add_lat", 64'(exp_done - exp_start), 2);

      run_op(4'h0, 32'hFFFFFFFF, 32'd1, 16'h0, 0, 0);
      chk("addwrap", {ALU_out, zero, carry, ovf}, {32'h0, 1'b1, 1'b1, 1'b0});
      run_op(4'h0, 32'h7FFFFFFF, 32'd1, 16'h0, 0, 0);
      chk("addovf", {ALU_out, ovf}, {32'h80000000, 1'b1});
      run_op(4'h1, 32'd3, 32'd5, 16'h0, 0, 0);
      chk("sub3_5", {ALU_out, carry}, {32'hFFFFFFFE, 1'b0});

      run_op(4'hB, 32'd0, 32'hDEADBEEF, 16'h0010, 0, 0);
      run_op(4'hA, 32'd0, 32'd0, 16'h0110, 0, 0);
      chk("load_wrap", 64'(Data_out), 64'(32'hDEADBEEF));
      chk("load_lat", 64'(exp_done - exp_start), 3);

      run_op(4'hB, 32'd0, 32'd10, 16'h0004, 0, 0);
      run_op(4'h0, 32'd99, 32'd3, 16'h0004, 1, 1);
      chk("asel_add", 64'(ALU_out), 13);

      @(posedge clk); #2;
      op = 4'hB; A = '0; B = 32'h12345678; ADD = 16'h0010; Asel = 0; start = 1;
      @(posedge clk); #2;
      start = 0; chk_en = 0; rst = 0;
      repeat (2) begin
         @(negedge clk);
         chk("abort_done", 64'(done), 0);
      end
      @(posedge clk); #2;
      reset_model(); rst = 1; chk_en = 1;
      run_op(4'hA, 32'd0, 32'd0, 16'h0010, 0, 0);
      chk("abort_nowrite", 64'(Data_out), 64'(32'hDEADBEEF));

      run_op(4'hE, 32'd1, 32'd2, 16'h0, 0, 0);
      chk("illegal", {ALU_out, err}, {32'h0, 1'b1});
      run_op(4'h2, 32'h0000F0F0, 32'h0000FF00, 16'h0, 0, 0);
      chk("and_clr", {ALU_out, err}, {32'h0000F000, 1'b0});

      for (int i = 0; i < 9; i++) begin
         run_op(vt[i].o, vt[i].a, vt[i].b, 16'h0, 0, 0);
         chk("vec", {ALU_out, carry, ovf}, {vt[i].r, vt[i].c, vt[i].v});
      end

      run_op(4'hB, 32'd0, 32'h0BADCAFE, 16'h0004, 1, 0);
      chk("asel_store_rd", 64'(Data_out), 10);
      run_op(4'hA, 32'd0, 32'd0, 16'h0104, 0, 0);
      chk("asel_store_wr", 64'(ALU_out), 64'(32'h0BADCAFE));

      run_op(4'hD, 32'd3, 32'd4, 16'h0, 0, 0);
`ifdef RISC_MAC_EN
      chk("mac1", 64'(ALU_out), 12);
      chk("mac_lat", 64'(exp_done - exp_start), 3);
      run_op(4'hD, 32'd3, 32'd4, 16'h0, 0, 0);
      chk("mac2", 64'(ALU_out), 24);
`else
      chk("mac_illegal", {ALU_out, err}, {32'h0, 1'b1});
`endif

      repeat (3) @(posedge clk);
      #2 chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/risc_exec_unit.md
Name: risc_exec_unit

Overview:
Parametrised successor to the 32-bit RISC top-level execute path. It combines the ALU with a word-addressed data memory. Operand A comes either from the A port or from memory at ADD, selected by Asel. A multi-cycle FSM with a start/done handshake sequences each operation and drives registered ALU_out, Data_out and status flags.

Parameters:
DW, 32, datapath width in bits (>=8).
AW, 16, width of the ADD address port.
DEPTH, 256, data-memory depth in words (power of 2, <=2**AW); index = ADD[$clog2(DEPTH)-1:0].

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
start  input  1  begin operation; sampled only in IDLE
op  input  4  opcode, captured with start
A  input  DW  operand A (used when Asel=0)
B  input  DW  operand B / store data
ADD  input  AW  memory word address
Asel  input  1  0: opA=A; 1: opA=mem[ADD]
busy  output  1  high from the cycle after start accepted until done
done  output  1  one-cycle pulse, result valid
ALU_out  output  DW  registered ALU result
Data_out  output  DW  registered memory read data
zero  output  1  ALU_out==0
carry  output  1  carry-out (ADD) / no-borrow (SUB)
ovf  output  1  signed overflow (ADD/SUB)
err  output  1  illegal opcode on last op

Behaviour:
- One clock, reset is synchronous and active-low: when rst=0 at a rising edge, FSM->IDLE and busy, done, ALU_out, Data_out, zero, carry, ovf, err all go to 0. Memory contents are not reset.
- Reset mid-operation aborts the operation: no done pulse, and a pending STORE does not write.
- Inputs op, A, B, ADD and Asel are latched on the edge where start=1 in IDLE. Later input changes are ignored until the next accepted start.
- start while busy, or in WB, is ignored (not queued).
- FSM states and transitions:
  - IDLE: on start, go to FETCH if Asel=1 or op=LOAD; otherwise go to EXEC.
  - FETCH: synchronous memory read of mem[idx]; go to EXEC.
  - EXEC: compute the result; STORE writes here; go to WB.
  - WB: register outputs, pulse done=1, busy=0; go to IDLE.
- Latency from the start edge to the done-high cycle: 2 cycles without FETCH, 3 cycles with FETCH. Back-to-back start in the cycle after done is accepted.
- Opcodes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 PASS B
  - 7 SLL, 8 SRL, 9 SRA, by B[$clog2(DW)-1:0]
  - A LOAD (Data_out=mem[idx], ALU_out=mem[idx])
  - B STORE (mem[idx]=B, ALU_out=B)
  - C/D see Optional Feature
  - E/F illegal
- Width rules: all results are truncated to DW. carry = bit DW of the (DW+1)-bit sum. For SUB, carry=1 means A>=B unsigned. ovf uses the standard sign rule.
- Flag updates at WB: carry and ovf update only on ADD/SUB and are cleared on every other op. zero reflects the new ALU_out.
- Data_out updates only on ops that perform FETCH and holds otherwise. ALU_out holds between operations.
- Illegal opcode: ALU_out=0, err=1, done still pulses, no memory write. err clears on the next legal op.
- Addressing: ADD bits above the index are ignored, so addresses wrap modulo DEPTH.
- STORE followed by a LOAD from the same address returns the new data (write completes in EXEC, before the next FETCH).
- Asel=1 together with op=STORE reads mem[idx] into Data_out, then overwrites that same word with B.

Optional Feature:
RISC_MAC_EN
- Defined:
  - op C = MUL: ALU_out = low DW bits of A*B, flags carry/ovf=0.
  - op D = MAC: acc = acc + A*B (low DW bits), ALU_out = acc.
  - acc is an internal DW-bit register, reset to 0. MAC adds one extra EXEC cycle, so latency is 3 (4 with FETCH).
- Not defined: op C and D are illegal (err=1, ALU_out=0); no multiplier or accumulator is synthesised.

Test Plan:
- Reset: rst=0 for 2 cycles with start=1 -> all outputs 0, no done; release, then ADD A=5 B=7 -> done 2 cycles after start, ALU_out=12, zero=0, carry=0.
- Arithmetic flags: ADD A=FFFFFFFF B=1 -> ALU_out=0, zero=1, carry=1, ovf=0. ADD A=7FFFFFFF B=1 -> ALU_out=80000000, ovf=1. SUB A=3 B=5 -> ALU_out=FFFFFFFE, carry=0.
- Memory: STORE ADD=0x0010 B=DEADBEEF, then LOAD ADD=0x0110 (wraps to idx 0x10 at DEPTH=256) -> Data_out=DEADBEEF, done 3 cycles after start.
- Asel path: mem[4]=10, start op=ADD Asel=1 ADD=4 B=3 A=99 -> ALU_out=13, latency 3; start pulsed again while busy -> ignored, exactly one done.
- Abort and illegal op: STORE with rst=0 asserted in EXEC -> memory word unchanged, no done. op=E -> err=1, ALU_out=0; next AND clears err.
- With RISC_MAC_EN defined: MAC A=3 B=4 twice -> ALU_out=12 then 24, latency 3. Without the macro: same op -> err=1.
